// File: rtl/sign_extend_scheduler.sv
// Round-robin scheduler that sign-extends one requester operand per cycle into a registered output.
// Optional SIGN_EXTEND_SCHEDULER_UNSIGNED_EN adds req_unsigned for per-requester zero-extension.
module sign_extend_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
`ifdef SIGN_EXTEND_SCHEDULER_UNSIGNED_EN
    input  logic [NUM_REQ-1:0]             req_unsigned,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUTPUT_WIDTH-1:0]        out_data,
    output logic [ID_WIDTH-1:0]            out_id
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam int unsigned NREQ_U = NUM_REQ;
    localparam int          EXT_W  = OUTPUT_WIDTH - INPUT_WIDTH;

    logic [0:0]             state;
    logic [ID_WIDTH-1:0]    ptr;
    logic                   can_accept;
    logic                   found;
    logic                   transfer;
    logic [ID_WIDTH-1:0]    win_id;
    logic [INPUT_WIDTH-1:0] win_operand;
    logic                   win_unsigned;
    logic                   fill;
    logic [OUTPUT_WIDTH-1:0] ext_data;
    logic [ID_WIDTH-1:0]    ptr_next;
    int unsigned            scan_idx;

    assign out_valid  = (state == FULL);
    assign can_accept = !out_valid || out_ready;
    assign transfer   = found && can_accept;

    // Scan offsets 0..NUM_REQ-1 from ptr with an explicit wrap so non-power-of-two counts work.
    always_comb begin
        found        = 1'b0;
        win_id       = '0;
        win_operand  = '0;
        win_unsigned = 1'b0;
        scan_idx     = 0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            scan_idx = {{(32-ID_WIDTH){1'b0}}, ptr} + k;
            if (scan_idx >= NREQ_U) begin
                scan_idx = scan_idx - NREQ_U;
            end
            if (!found && req_valid[scan_idx]) begin
                found       = 1'b1;
                win_id      = scan_idx[ID_WIDTH-1:0];
                win_operand = req_data[scan_idx*INPUT_WIDTH +: INPUT_WIDTH];
`ifdef SIGN_EXTEND_SCHEDULER_UNSIGNED_EN
                win_unsigned = req_unsigned[scan_idx];
`endif
            end
        end
    end

    assign fill     = win_operand[INPUT_WIDTH-1] & ~win_unsigned;
    assign ext_data = {{EXT_W{fill}}, win_operand};
    assign ptr_next = (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= '0;
            ptr      <= '0;
        end else if (transfer) begin
            state    <= FULL;
            out_data <= ext_data;
            out_id   <= win_id;
            ptr      <= ptr_next;
        end else if (state == FULL && out_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_sign_extend_scheduler.sv
// Scoreboard bench for sign_extend_scheduler: stimulus predicts grants and results, a monitor checks outputs.
module tb_sign_extend_scheduler;

    localparam int N   = 4;
    localparam int IW  = 8;
    localparam int OW  = 16;
    localparam int IDW = 2;
`ifdef SIGN_EXTEND_SCHEDULER_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*IW-1:0] req_data = '0;
`ifdef SIGN_EXTEND_SCHEDULER_UNSIGNED_EN
    logic [N-1:0]    req_unsigned = '0;
`endif
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OW-1:0]   out_data;
    logic [IDW-1:0]  out_id;

    int n_checks = 0;
    int n_pass   = 0;

    logic [IDW+OW-1:0] exp_q[$];
    int m_ptr  = 0;
    bit m_full = 1'b0;

    sign_extend_scheduler #(
        .NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
`ifdef SIGN_EXTEND_SCHEDULER_UNSIGNED_EN
        .req_unsigned(req_unsigned),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_id(out_id)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endfunction

    // Two's-complement widening done with integer arithmetic.
    function automatic logic [OW-1:0] widen(input logic [IW-1:0] v, input bit uns);
        longint s;
        s = longint'(v);
        if (!uns && s >= (longint'(1) << (IW-1))) s = s - (longint'(1) << IW);
        return OW'(s);
    endfunction

    function automatic logic [N*IW-1:0] pack4(input logic [IW-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N*IW-1:0] d, input logic rdy,
                        input logic [N-1:0] u);
        int w;
        bit acc;
        bit uns;
        logic [N-1:0] exp_rdy;
        @(posedge clk); #1;
        check("out_valid", 32'(out_valid), 32'(m_full));
        req_valid = v;
        req_data  = d;
        out_ready = rdy;
`ifdef SIGN_EXTEND_SCHEDULER_UNSIGNED_EN
        req_unsigned = u;
`endif
        #1;
        acc = !m_full || rdy;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && v[i]) w = i;
        end
        exp_rdy = '0;
        if (w >= 0 && acc) exp_rdy[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (w >= 0 && acc) begin
            uns = UNS_EN && u[w];
            exp_q.push_back({IDW'(w), widen(d[w*IW +: IW], uns)});
            m_ptr  = (w + 1) % N;
            m_full = 1'b1;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    // Monitor: every presented result must match the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("mon_data", 32'(out_data), 32'(exp_q[0][OW-1:0]));
                    check("mon_id", 32'(out_id), 32'(exp_q[0][IDW+OW-1:OW]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N*IW-1:0] mix;
        mix = pack4(8'h01, 8'h7F, 8'hFF, 8'h80);

        do_reset();

        // Single requester 2 with 0x80.
        step(4'b0100, pack4(8'h00, 8'h00, 8'h80, 8'h00), 1'b1, '0);
        step(4'b0000, '0, 1'b0, '0);
        check("t1_data", 32'(out_data), 32'h0000FF80);
        check("t1_id", 32'(out_id), 32'd2);
        step(4'b0000, '0, 1'b1, '0);

        // All four valid from ptr=0, including wrap back to requester 0.
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b1111, mix, 1'b1, '0);

        // Backpressure with pending result, then release.
        for (int i = 0; i < 3; i++) step(4'b1111, mix, 1'b0, '0);
        for (int i = 0; i < 2; i++) step(4'b1111, mix, 1'b1, '0);
        step(4'b0000, '0, 1'b1, '0);

        // Move ptr to 2, then only requesters 1 and 3.
        do_reset();
        step(4'b0010, mix, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(4'b1010, mix, 1'b1, '0);
        step(4'b0000, '0, 1'b1, '0);

        // Reset while a result is held and ptr=3; next grant goes to 0.
        step(4'b0100, mix, 1'b1, '0);
        step(4'b0000, '0, 1'b0, '0);
        do_reset();
        step(4'b1111, mix, 1'b1, '0);
        step(4'b0000, '0, 1'b1, '0);

`ifdef SIGN_EXTEND_SCHEDULER_UNSIGNED_EN
        step(4'b0010, pack4(8'h00, 8'hF0, 8'h00, 8'h00), 1'b1, 4'b0010);
        step(4'b0010, pack4(8'h00, 8'hF0, 8'h00, 8'h00), 1'b1, 4'b0000);
        step(4'b0000, '0, 1'b1, '0);
`endif

        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), N*IW'($urandom), ($urandom_range(0, 3) != 0), N'($urandom));
        end
        for (int i = 0; i < 3; i++) step(4'b0000, '0, 1'b1, '0);
        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
